ram_32_56_arb: RTL

//  Sequencer/arbiter in front of one ram_32_56 instance: 1 read port, 1 write port, 32x56b, 1-cycle read.

---
 rtl/ram_32_56_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/ram_32_56_arb.sv
// Sequencer/arbiter in front of a 32x56 one-read/one-write table RAM: clears the array
// after reset or flush, round-robins two writers onto the write port and forwards same-cycle writes to the reader.
module ram_32_56_arb #(
    parameter int AW = 5,
    parameter int DW = 56,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    output logic          init_busy,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wa_req,
    input  logic [AW-1:0] wa_addr,
    input  logic [DW-1:0] wa_data,
    output logic          wa_gnt,
    input  logic          wb_req,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          wb_gnt,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rd,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wr
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic RR_A    = 1'b0;
    localparam logic RR_B    = 1'b1;

    logic          state;
    logic [AW-1:0] cnt;
    logic          rr;
    logic          vld_p1;
    logic          fwd_p1;
    logic [DW-1:0] fwd_data_p1;
    logic          fwd_hit;

    always_comb begin
        init_busy = 1'b0;
        rd_ready  = 1'b0;
        ram_re    = 1'b0;
        ram_raddr = rd_addr;
        wa_gnt    = 1'b0;
        wb_gnt    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = cnt;
        ram_wr    = INIT_VAL;
        if (!rst) begin
            init_busy = 1'b1;
        end else if (state == ST_INIT) begin
            init_busy = 1'b1;
            ram_we    = 1'b1;
        end else begin
            rd_ready = rd_req;
            ram_re   = rd_req;
            // The flush cycle itself grants nothing; requests simply wait out the sweep.
            if (!flush) begin
                if (wa_req && (!wb_req || rr == RR_A)) begin
                    wa_gnt    = 1'b1;
                    ram_we    = 1'b1;
                    ram_waddr = wa_addr;
                    ram_wr    = wa_data;
                end else if (wb_req) begin
                    wb_gnt    = 1'b1;
                    ram_we    = 1'b1;
                    ram_waddr = wb_addr;
                    ram_wr    = wb_data;
                end
            end
        end
    end

    // The RAM returns the pre-write word on a same-address collision, so remember the new one.
    assign fwd_hit = rd_ready && (wa_gnt || wb_gnt) && (ram_waddr == rd_addr);

    // Stage p0 -> p1: read accept, forwarding capture, sweep/arbitration state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_INIT;
            cnt    <= '0;
            rr     <= RR_A;
            vld_p1 <= 1'b0;
            fwd_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_ready;
            fwd_p1 <= fwd_hit;
            if (state == ST_INIT) begin
                if (flush) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= ST_RUN;
                end
            end else if (flush) begin
                state <= ST_INIT;
                cnt   <= '0;
            end
            if (wa_gnt)      rr <= RR_B;
            else if (wb_gnt) rr <= RR_A;
        end
    end

    always_ff @(posedge clk) begin
        fwd_data_p1 <= ram_wr;
    end

    // Stage p1: output select
    assign rd_valid = vld_p1 && rst;
    assign rd_data  = rd_valid ? (fwd_p1 ? fwd_data_p1 : ram_rd) : '0;

endmodule
